// File: rtl/fg_pkg.sv
// Shared definitions for the function-generator DAC sequencer: FSM state
// encoding, default timing constants and counter sizing helpers.
package fg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_SETTLE = 3'd3,
    ST_CLEAR  = 3'd4
  } fg_state_e;

  localparam int unsigned FG_BITWIDTH        = 8;
  localparam int unsigned FG_SETUP_CYCLES    = 1;
  localparam int unsigned FG_WR_CYCLES       = 2;
  localparam int unsigned FG_SETTLE_BITWIDTH = 16;
  localparam int unsigned FG_CLR_CYCLES      = 2;

  function automatic int unsigned fg_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // One shared down-counter times every phase, so it must hold the widest load.
  function automatic int unsigned fg_cnt_width(input int unsigned settle_w,
                                               input int unsigned max_cycles);
    return fg_max(settle_w, $clog2(max_cycles + 1));
  endfunction

endpackage

// File: rtl/fg_sample_fifo.sv
// Two-entry sample FIFO; a push while full is accepted only alongside a pop.
module fg_sample_fifo
  import fg_pkg::*;
#(
  parameter int unsigned WIDTH = FG_BITWIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic             rd_q, rd_d;
  logic             wr_q, wr_d;
  logic [1:0]       count_q, count_d;
  logic             do_pop_s, do_push_s;

  assign empty_o = (count_q == 2'd0);
  assign full_o  = (count_q == 2'd2);
  assign data_o  = mem_q[rd_q];

  // Pointer, storage and occupancy update; flush overrides push and pop
  always_comb begin
    mem_d     = mem_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    count_d   = count_q;
    do_pop_s  = pop_i && !empty_o;
    do_push_s = push_i && (!full_o || do_pop_s);
    if (flush_i) begin
      rd_d    = 1'b0;
      wr_d    = 1'b0;
      count_d = 2'd0;
    end else begin
      if (do_pop_s) begin
        rd_d = !rd_q;
      end else begin
        rd_d = rd_q;
      end
      if (do_push_s) begin
        mem_d[wr_q] = data_i;
        wr_d        = !wr_q;
      end else begin
        wr_d = wr_q;
      end
      if (do_push_s && !do_pop_s) begin
        count_d = count_q + 2'd1;
      end else if (do_pop_s && !do_push_s) begin
        count_d = count_q - 2'd1;
      end else begin
        count_d = count_q;
      end
    end
  end

  // FIFO registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q[0] <= {WIDTH{1'b0}};
      mem_q[1] <= {WIDTH{1'b0}};
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fg_dac_sequencer.sv
// Parallel-DAC write sequencer: buffers generator samples and issues each one
// with data setup, an active-low WR pulse and a programmable settle gap.
module fg_dac_sequencer
  import fg_pkg::*;
#(
  parameter int unsigned BITWIDTH        = FG_BITWIDTH,
  parameter int unsigned SETUP_CYCLES    = FG_SETUP_CYCLES,
  parameter int unsigned WR_CYCLES       = FG_WR_CYCLES,
  parameter int unsigned SETTLE_BITWIDTH = FG_SETTLE_BITWIDTH,
  parameter int unsigned CLR_CYCLES      = FG_CLR_CYCLES
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable_i,
  input  logic [BITWIDTH-1:0]        sample_i,
  input  logic                       sample_valid_i,
  input  logic [SETTLE_BITWIDTH-1:0] settle_i,
  input  logic                       clr_req_i,
  input  logic                       pd_req_i,
  output logic [BITWIDTH-1:0]        dac_data_o,
  output logic                       dac_wr_n_o,
  output logic                       dac_clr_n_o,
  output logic                       dac_pd_n_o,
  output logic                       busy_o,
  output logic                       overflow_o
);

  localparam int unsigned CNT_W =
    fg_cnt_width(SETTLE_BITWIDTH, fg_max(fg_max(SETUP_CYCLES, WR_CYCLES), CLR_CYCLES));
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] WR_LD    = CNT_W'(WR_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLR_LD   = CNT_W'(CLR_CYCLES - 1);

  fg_state_e             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [BITWIDTH-1:0]   data_q, data_d;
  logic                  wr_n_q, wr_n_d;
  logic                  clr_n_q, clr_n_d;
  logic                  pd_n_q, pd_n_d;
  logic                  busy_q, busy_d;
  logic                  ovf_q, ovf_d;
  logic                  clr_pend_q, clr_pend_d;

  logic                  pop_s, go_clear_s, flush_s, push_s, drop_s;
  logic [BITWIDTH-1:0]   fifo_data_s;
  logic                  fifo_full_s, fifo_empty_s;

  fg_sample_fifo #(.WIDTH(BITWIDTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush_s),
    .push_i  (push_s),
    .data_i  (sample_i),
    .pop_i   (pop_s),
    .data_o  (fifo_data_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  // Sequencing FSM: each timed phase loads the counter with its length minus one
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    pop_s      = 1'b0;
    go_clear_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clr_pend_q || clr_req_i) begin
          go_clear_s = 1'b1;
          state_d    = ST_CLEAR;
          cnt_d      = CLR_LD;
          data_d     = {BITWIDTH{1'b0}};
        end else if (enable_i && !fifo_empty_s) begin
          pop_s   = 1'b1;
          data_d  = fifo_data_s;
          state_d = ST_SETUP;
          cnt_d   = SETUP_LD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (cnt_q == CNT_ZERO) begin
          state_d = ST_STROBE;
          cnt_d   = WR_LD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_STROBE: begin
        if (cnt_q != CNT_ZERO) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (settle_i == {SETTLE_BITWIDTH{1'b0}}) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SETTLE;
          cnt_d   = CNT_W'(settle_i) - CNT_ONE;
        end
      end
      ST_SETTLE, ST_CLEAR: begin
        if (cnt_q == CNT_ZERO) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Buffer control, sticky overflow, deferred clear and next output values
  always_comb begin
    flush_s = !enable_i || go_clear_s || (state_q == ST_CLEAR);
    push_s  = sample_valid_i && !flush_s;
    drop_s  = push_s && fifo_full_s && !pop_s;
    if (go_clear_s || (state_q == ST_CLEAR)) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q || drop_s;
    end
    if (go_clear_s) begin
      clr_pend_d = 1'b0;
    end else if (clr_req_i && (state_q != ST_IDLE)) begin
      clr_pend_d = 1'b1;
    end else begin
      clr_pend_d = clr_pend_q;
    end
    wr_n_d  = (state_d != ST_STROBE);
    clr_n_d = (state_d != ST_CLEAR);
    busy_d  = (state_d != ST_IDLE);
    pd_n_d  = !pd_req_i;
  end

  // State, counter and glitch-free output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= CNT_ZERO;
      data_q     <= {BITWIDTH{1'b0}};
      wr_n_q     <= 1'b1;
      clr_n_q    <= 1'b0;
      pd_n_q     <= 1'b1;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
      clr_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      wr_n_q     <= wr_n_d;
      clr_n_q    <= clr_n_d;
      pd_n_q     <= pd_n_d;
      busy_q     <= busy_d;
      ovf_q      <= ovf_d;
      clr_pend_q <= clr_pend_d;
    end
  end

  assign dac_data_o  = data_q;
  assign dac_wr_n_o  = wr_n_q;
  assign dac_clr_n_o = clr_n_q;
  assign dac_pd_n_o  = pd_n_q;
  assign busy_o      = busy_q;
  assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_fg_dac_sequencer.sv
// Self-checking bench for fg_dac_sequencer: a timeline model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_fg_dac_sequencer;

  localparam int S = 1;
  localparam int W = 2;
  localparam int C = 2;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [7:0]  sample;
  logic        valid;
  logic [15:0] settle;
  logic        clr_req;
  logic        pd_req;
  logic [7:0]  dac_data_o;
  logic        dac_wr_n_o, dac_clr_n_o, dac_pd_n_o, busy_o, overflow_o;

  int checks   = 0;
  int failures = 0;

  fg_dac_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable_i       (enable),
    .sample_i       (sample),
    .sample_valid_i (valid),
    .settle_i       (settle),
    .clr_req_i      (clr_req),
    .pd_req_i       (pd_req),
    .dac_data_o     (dac_data_o),
    .dac_wr_n_o     (dac_wr_n_o),
    .dac_clr_n_o    (dac_clr_n_o),
    .dac_pd_n_o     (dac_pd_n_o),
    .busy_o         (busy_o),
    .overflow_o     (overflow_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Timeline model: state after edge m_n, expressed as edge-index windows.
  int         m_n = 0;
  logic [7:0] m_q[$];
  logic [7:0] m_data = 8'h00;
  bit         m_ovf = 1'b0, m_pend = 1'b0, m_pd_n = 1'b1, m_rst = 1'b1, m_clr_kind = 1'b0;
  int         m_idle_from = 0, m_settle_at = -1;
  int         m_wr_s = -1, m_wr_e = -2, m_clr_s = -1, m_clr_e = -2;
  logic [7:0] wr_log[$];

  initial begin
    bit prev_wr_n;
    prev_wr_n = 1'b1;
    forever begin
      @(negedge clk);
      chk($sformatf("data@%0d", m_n), 32'(dac_data_o), 32'(m_data));
      chk($sformatf("wr_n@%0d", m_n), 32'(dac_wr_n_o), 32'(!(m_n >= m_wr_s && m_n <= m_wr_e)));
      chk($sformatf("clr_n@%0d", m_n), 32'(dac_clr_n_o),
          32'(m_rst ? 1'b0 : !(m_n >= m_clr_s && m_n <= m_clr_e)));
      chk($sformatf("pd_n@%0d", m_n), 32'(dac_pd_n_o), 32'(m_pd_n));
      chk($sformatf("busy@%0d", m_n), 32'(busy_o), 32'(m_n < m_idle_from));
      chk($sformatf("ovf@%0d", m_n), 32'(overflow_o), 32'(m_ovf));
      if (prev_wr_n && !dac_wr_n_o) wr_log.push_back(dac_data_o);
      prev_wr_n = dac_wr_n_o;
      // advance the model to the coming edge using the inputs it will sample
      begin
        int  k;
        bit  idle, in_clear, pend_now, go_clear, go_tx, flush;
        k = m_n + 1;
        if (!rst_n) begin
          m_q.delete();
          m_data = 8'h00; m_ovf = 1'b0; m_pend = 1'b0; m_pd_n = 1'b1; m_rst = 1'b1;
          m_clr_kind = 1'b0; m_idle_from = k; m_settle_at = -1;
          m_wr_s = -1; m_wr_e = -2; m_clr_s = -1; m_clr_e = -2;
        end else begin
          m_rst    = 1'b0;
          idle     = (k - 1 >= m_idle_from);
          in_clear = m_clr_kind && !idle;
          if (m_settle_at == k) begin
            m_idle_from = k + int'(settle);
            m_settle_at = -1;
          end
          pend_now = m_pend || clr_req;
          go_clear = idle && pend_now;
          go_tx    = idle && !pend_now && enable && (m_q.size() > 0);
          flush    = !enable || go_clear || in_clear;
          if (go_tx) begin
            m_data = m_q.pop_front();
            m_wr_s = k + S; m_wr_e = k + S + W - 1;
            m_settle_at = k + S + W; m_idle_from = k + S + W;
            m_clr_kind = 1'b0;
          end
          if (go_clear) begin
            m_data = 8'h00; m_clr_s = k; m_clr_e = k + C - 1;
            m_idle_from = k + C; m_clr_kind = 1'b1; m_pend = 1'b0;
          end else if (!idle && clr_req) begin
            m_pend = 1'b1;
          end
          if (flush) m_q.delete();
          else if (valid) begin
            if (m_q.size() < 2) m_q.push_back(sample);
            else m_ovf = 1'b1;
          end
          if (go_clear || in_clear) m_ovf = 1'b0;
          m_pd_n = !pd_req;
        end
        m_n = k;
      end
    end
  end

  initial begin
    int         base;
    logic [0:8] wr_pat;
    logic [0:8] busy_pat;
    rst_n = 1'b0; enable = 1'b1; sample = 8'h00; valid = 1'b0;
    settle = 16'd4; clr_req = 1'b0; pd_req = 1'b0;
    tick(2);
    chk("rst_data", 32'(dac_data_o), 32'h00);
    chk("rst_wr_n", 32'(dac_wr_n_o), 32'h1);
    chk("rst_clr_n", 32'(dac_clr_n_o), 32'h0);
    chk("rst_pd_n", 32'(dac_pd_n_o), 32'h1);
    chk("rst_busy", 32'(busy_o), 32'h0);
    rst_n = 1'b1;
    tick(1);
    chk("idle_clr_n", 32'(dac_clr_n_o), 32'h1);
    pd_req = 1'b1; tick(1); chk("pd_low", 32'(dac_pd_n_o), 32'h0);
    pd_req = 1'b0; tick(1); chk("pd_high", 32'(dac_pd_n_o), 32'h1);

    // single sample, settle 4
    sample = 8'hA5; valid = 1'b1; tick(1); valid = 1'b0;
    chk("s1_busy_E", 32'(busy_o), 32'h0);
    tick(1);
    chk("s1_data_E1", 32'(dac_data_o), 32'hA5);
    chk("s1_model_data", 32'(m_data), 32'hA5);
    chk("s1_wr_E1", 32'(dac_wr_n_o), 32'h1);
    tick(1); chk("s1_wr_E2", 32'(dac_wr_n_o), 32'h0);
    tick(1); chk("s1_wr_E3", 32'(dac_wr_n_o), 32'h0);
    tick(1); chk("s1_wr_E4", 32'(dac_wr_n_o), 32'h1);
    tick(3); chk("s1_busy_E7", 32'(busy_o), 32'h1);
    tick(1); chk("s1_busy_E8", 32'(busy_o), 32'h0);
    chk("s1_model_busy", 32'(m_n < m_idle_from), 32'h0);

    // overflow: three valids while a write is settling
    settle = 16'd10; base = wr_log.size();
    sample = 8'h10; valid = 1'b1; tick(1); valid = 1'b0;
    tick(5);
    valid = 1'b1;
    sample = 8'h11; tick(1);
    sample = 8'h22; tick(1);
    chk("ov_before", 32'(overflow_o), 32'h0);
    sample = 8'h33; tick(1); valid = 1'b0;
    chk("ov_set", 32'(overflow_o), 32'h1);
    tick(70);
    chk("ov_pulses", 32'(wr_log.size() - base), 32'd3);
    if (wr_log.size() >= base + 3) begin
      chk("ov_d0", 32'(wr_log[base]), 32'h10);
      chk("ov_d1", 32'(wr_log[base + 1]), 32'h11);
      chk("ov_d2", 32'(wr_log[base + 2]), 32'h22);
    end
    chk("ov_sticky", 32'(overflow_o), 32'h1);

    // clear requested mid-strobe is deferred until after settle
    settle = 16'd3;
    sample = 8'h5A; valid = 1'b1; tick(1); valid = 1'b0;
    tick(2); clr_req = 1'b1; tick(1); clr_req = 1'b0;
    chk("cl_wr_E3", 32'(dac_wr_n_o), 32'h0);
    tick(1); chk("cl_wr_E4", 32'(dac_wr_n_o), 32'h1);
    tick(3);
    chk("cl_clr_E7", 32'(dac_clr_n_o), 32'h1);
    chk("cl_busy_E7", 32'(busy_o), 32'h0);
    tick(1);
    chk("cl_clr_E8", 32'(dac_clr_n_o), 32'h0);
    chk("cl_data_E8", 32'(dac_data_o), 32'h00);
    chk("cl_ovf_E8", 32'(overflow_o), 32'h0);
    tick(1); chk("cl_clr_E9", 32'(dac_clr_n_o), 32'h0);
    tick(1); chk("cl_clr_E10", 32'(dac_clr_n_o), 32'h1);
    chk("cl_busy_E10", 32'(busy_o), 32'h0);

    // settle 0, back-to-back samples
    settle = 16'd0;
    wr_pat   = 9'b1_0011_0011;
    busy_pat = 9'b1_1101_1100;
    sample = 8'h01; valid = 1'b1; tick(1);
    sample = 8'h02; tick(1); valid = 1'b0;
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("b2b_wr_%0d", i + 1), 32'(dac_wr_n_o), 32'(wr_pat[i]));
      chk($sformatf("b2b_busy_%0d", i + 1), 32'(busy_o), 32'(busy_pat[i]));
      chk($sformatf("b2b_data_%0d", i + 1), 32'(dac_data_o), (i < 4) ? 32'h01 : 32'h02);
      tick(1);
    end

    // disable with two buffered samples
    settle = 16'd5; base = wr_log.size();
    valid = 1'b1;
    sample = 8'h31; tick(1);
    sample = 8'h32; tick(1);
    sample = 8'h33; tick(1); valid = 1'b0;
    tick(1); enable = 1'b0;
    tick(20);
    chk("dis_pulses", 32'(wr_log.size() - base), 32'd1);
    if (wr_log.size() > base) chk("dis_d0", 32'(wr_log[base]), 32'h31);
    chk("dis_busy", 32'(busy_o), 32'h0);
    enable = 1'b1; tick(5);
    chk("dis_flushed", 32'(busy_o), 32'h0);

    // reset in the middle of a strobe
    settle = 16'd2; base = wr_log.size();
    valid = 1'b1;
    sample = 8'h77; tick(1);
    sample = 8'h78; tick(1); valid = 1'b0;
    tick(1);
    chk("rs_wr_before", 32'(dac_wr_n_o), 32'h0);
    rst_n = 1'b0; tick(1);
    chk("rs_wr", 32'(dac_wr_n_o), 32'h1);
    chk("rs_clr", 32'(dac_clr_n_o), 32'h0);
    chk("rs_data", 32'(dac_data_o), 32'h00);
    rst_n = 1'b1; tick(10);
    chk("rs_busy", 32'(busy_o), 32'h0);
    chk("rs_pulses", 32'(wr_log.size() - base), 32'd1);

    tick(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fg_dac_sequencer.md
FG_DAC_SEQUENCER -- requirements
Module: fg_dac_sequencer

Interface
REQ-001 SHALL have parameter BITWIDTH, default 8, DAC sample width.
REQ-002 SHALL have parameter SETUP_CYCLES, default 1, data-to-WR setup time in clocks (>=1).
REQ-003 SHALL have parameter WR_CYCLES, default 2, WR low pulse width in clocks (>=1).
REQ-004 SHALL have parameter SETTLE_BITWIDTH, default 16, width of the settle-time count.
REQ-005 SHALL have parameter CLR_CYCLES, default 2, DAC clear pulse width in clocks (>=1).
REQ-006 clk  input  1  clock.
REQ-007 rst_n  input  1  reset, synchronous, active-low.
REQ-008 enable_i  input  1  1 = accept and issue samples.
REQ-009 sample_i  input  BITWIDTH  sample from waveform generator.
REQ-010 sample_valid_i  input  1  single-cycle strobe qualifying sample_i.
REQ-011 settle_i  input  SETTLE_BITWIDTH  post-write idle clocks (DAC settling).
REQ-012 clr_req_i  input  1  single-cycle DAC clear request.
REQ-013 pd_req_i  input  1  level, 1 = DAC power-down.
REQ-014 dac_data_o  output  BITWIDTH  registered DAC data bus.
REQ-015 dac_wr_n_o  output  1  registered DAC write strobe, active-low.
REQ-016 dac_clr_n_o  output  1  registered DAC clear, active-low.
REQ-017 dac_pd_n_o  output  1  registered DAC power-down, active-low.
REQ-018 busy_o  output  1  1 whenever state is not IDLE.
REQ-019 overflow_o  output  1  sticky: sample dropped on full buffer.

Function
REQ-020 SHALL buffer samples in a 2-entry FIFO; push on sample_valid_i when enable_i=1.
REQ-021 Push when full with simultaneous pop SHALL be accepted; push when full without pop SHALL drop the sample and set overflow_o.
REQ-022 FSM states SHALL be IDLE, SETUP, STROBE, SETTLE, CLEAR.
REQ-023 IDLE: pending clear -> CLEAR (priority); else FIFO non-empty and enable_i=1 -> pop into dac_data_o, go SETUP.
REQ-024 SETUP SHALL hold dac_wr_n_o=1 for SETUP_CYCLES clocks, then STROBE.
REQ-025 STROBE SHALL hold dac_wr_n_o=0 for WR_CYCLES clocks, dac_data_o stable, then SETTLE.
REQ-026 SETTLE SHALL count settle_i clocks (sampled on entry) then IDLE; settle_i=0 SHALL go STROBE -> IDLE directly.
REQ-027 Latency (defaults, empty FIFO, IDLE): valid captured at edge E; data on dac_data_o after E+1; dac_wr_n_o low after E+2 through E+4.
REQ-028 clr_req_i in any non-IDLE state SHALL be latched as pending and serviced on the next IDLE.
REQ-029 CLEAR SHALL drive dac_clr_n_o=0 for CLR_CYCLES clocks, flush FIFO, clear overflow_o, set dac_data_o=0, then IDLE.
REQ-030 enable_i=0 SHALL flush FIFO and block pushes; an in-flight transaction SHALL complete normally.
REQ-031 dac_pd_n_o SHALL equal registered !pd_req_i, independent of FSM state.
REQ-032 No glitches: all DAC outputs SHALL come directly from flops.

Reset
REQ-033 On rst_n=0 at a clock edge: state IDLE, FIFO empty, pending clear 0, counters 0.
REQ-034 Reset values: dac_data_o=0, dac_wr_n_o=1, dac_clr_n_o=0, dac_pd_n_o=1, busy_o=0, overflow_o=0.
REQ-035 Reset mid-strobe SHALL force dac_wr_n_o=1 on the same edge.

Structure
REQ-036 State encoding and default timing constants SHALL live in shared package fg_pkg.
REQ-037 FIFO SHALL be sub-module fg_sample_fifo (depth 2, push/pop/full/empty).

Verification
REQ-038 Single sample 0xA5, settle_i=4 -> dac_data_o=0xA5 after E+1, wr_n low exactly 2 clocks, busy_o low 4 clocks after wr_n rises.
REQ-039 Three valids on consecutive clocks, settle_i=10 -> third dropped, overflow_o=1, exactly two WR pulses with data 1st,2nd.
REQ-040 clr_req_i during STROBE -> WR completes, SETTLE completes, then clr_n low 2 clocks, overflow_o=0, dac_data_o=0.
REQ-041 settle_i=0, back-to-back samples 0x01,0x02 -> WR pulses separated only by SETUP, no SETTLE state entered.
REQ-042 rst_n low during STROBE -> next edge dac_wr_n_o=1, dac_clr_n_o=0, FIFO empty.
REQ-043 enable_i=0 with 2 buffered samples after current write -> no further WR pulse, busy_o=0.
